// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one integer ALU between two requesters,
// with registered ALU operands and a valid/ready response channel.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_Req0_Valid,
    output logic                  o_Req0_Ready,
    input  logic [3:0]            i_Req0_Ctrl,
    input  logic [DATA_WIDTH-1:0] i_Req0_A,
    input  logic [DATA_WIDTH-1:0] i_Req0_B,
    input  logic                  i_Req1_Valid,
    output logic                  o_Req1_Ready,
    input  logic [3:0]            i_Req1_Ctrl,
    input  logic [DATA_WIDTH-1:0] i_Req1_A,
    input  logic [DATA_WIDTH-1:0] i_Req1_B,
    output logic [3:0]            o_ALU_Ctrl,
    output logic [DATA_WIDTH-1:0] o_ALU_A,
    output logic [DATA_WIDTH-1:0] o_ALU_B,
    input  logic [DATA_WIDTH-1:0] i_ALU_Result,
    output logic                  o_Rsp_Valid,
    input  logic                  i_Rsp_Ready,
    output logic                  o_Rsp_Id,
    output logic [DATA_WIDTH-1:0] o_Rsp_Result,
    output logic                  o_Rsp_Zero,
    output logic                  o_Rsp_Err,
    output logic                  o_Busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state;
    logic                  last;
    logic                  id;
    logic                  err;
    logic                  window;
    logic                  gnt;
    logic                  accept;
    logic                  legal;
    logic [3:0]            ctrl;
    logic [DATA_WIDTH-1:0] result;

    // The response handshake cycle doubles as the next accept window.
    always_comb begin
        window = i_Rst_n && (state == IDLE || (state == RESP && o_Rsp_Valid && i_Rsp_Ready));
        gnt    = (i_Req0_Valid && i_Req1_Valid) ? ~last : i_Req1_Valid;
        accept = window && (i_Req0_Valid || i_Req1_Valid);
        ctrl   = gnt ? i_Req1_Ctrl : i_Req0_Ctrl;
        legal  = !ctrl[3] || ctrl[2:0] == 3'b000 || ctrl[2:0] == 3'b101;
        result = err ? '0 : i_ALU_Result;
    end

    assign o_Req0_Ready = window && !gnt;
    assign o_Req1_Ready = window && gnt;
    assign o_Busy       = state != IDLE;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state        <= IDLE;
            last         <= 1'b1;
            id           <= 1'b0;
            err          <= 1'b0;
            o_ALU_Ctrl   <= '0;
            o_ALU_A      <= '0;
            o_ALU_B      <= '0;
            o_Rsp_Valid  <= 1'b0;
            o_Rsp_Id     <= 1'b0;
            o_Rsp_Result <= '0;
            o_Rsp_Zero   <= 1'b0;
            o_Rsp_Err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) state <= ISSUE;
                ISSUE: begin
                    state        <= RESP;
                    o_Rsp_Valid  <= 1'b1;
                    o_Rsp_Result <= result;
                    o_Rsp_Zero   <= result == '0;
                    o_Rsp_Err    <= err;
                    o_Rsp_Id     <= id;
                end
                RESP: if (i_Rsp_Ready) begin
                    o_Rsp_Valid <= 1'b0;
                    state       <= accept ? ISSUE : IDLE;
                end
                default: state <= IDLE;
            endcase
            if (accept) begin
                last       <= gnt;
                id         <= gnt;
                err        <= !legal;
                o_ALU_Ctrl <= legal ? ctrl : 4'b0000;
                o_ALU_A    <= gnt ? i_Req1_A : i_Req0_A;
                o_ALU_B    <= gnt ? i_Req1_B : i_Req0_B;
            end
        end
    end
endmodule
